modn_cascade_counter: RTL and testbench
=======================================

Name: modn_cascade_counter

Overview:
- Parametrised synchronous successor to the team's modulo counters.
- DIGITS cascaded modulo-MOD digits; all flops clocked by clk, with no ripple clocking.
- Adds up/down direction, enable, synchronous load and clear, a cascade carry and a registered wrap pulse.
- Used as the time-base and display counter (e.g. mod-6/mod-10/mod-60 digit chains) feeding seven-segment and LED logic.

Parameters:
- MOD, 6, modulus of every digit; legal range 2..256.
- DIGITS, 2, number of cascaded digits; legal range 1..8.
- W, $clog2(MOD), bits per digit. Derived; never overridden.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  reset, asynchronous, active-low.
- en  in  1  count enable.
- up  in  1  direction: 1 = up, 0 = down.
- sclr  in  1  synchronous clear.
- load  in  1  synchronous parallel load.
- load_val  in  DIGITS*W  load value; digit i in bits [i*W +: W].
- q  out  DIGITS*W  count; digit 0 is least significant.
- carry_out  out  1  cascade carry (combinational).
- wrap  out  1  registered one-cycle pulse after a full-chain wrap.

Behaviour:
- Reset: clr low forces all q digits and wrap to 0 immediately, independent of clk.
  - While clr is low, carry_out is 0 because all digits are 0 and direction is up; when up=0, carry_out follows its definition below.
  - Release of clr takes effect from the next rising edge.
- Per-edge priority, highest first: sclr > load > en. Only one action is applied per edge.
- sclr=1: all digits go to 0; wrap goes to 0.
- load=1 (sclr=0): digit i takes load_val digit i.
  - Any loaded digit value >= MOD is clamped to MOD-1.
  - wrap goes to 0.
- en=1 (sclr=0, load=0):
  - Terminal value of a digit: MOD-1 when up=1, 0 when up=0.
  - Digit 0 always steps.
  - Digit i>0 steps only if every digit below i is at its terminal value in the same cycle.
  - Up step: MOD-1 -> 0, otherwise +1.
  - Down step: 0 -> MOD-1, otherwise -1.
- en=0 with no sclr/load: q holds.
- carry_out = en & (every digit at its terminal value for the current up).
  - Combinational, so the next chain instance can use it as its en within the same cycle.
  - Suppressed (0) whenever sclr or load is 1.
- wrap is registered: 1 for exactly one cycle after any edge where carry_out was 1, otherwise 0.
- Direction may change on any cycle. The new direction applies to that same edge; there is no pipeline or latency.
- Count latency: q updates on the rising edge at which en was sampled 1.
- Arithmetic: digits are unsigned W-bit values.
  - Out-of-range states are unreachable except by load, where clamping applies.
  - If an out-of-range state is reached anyway (e.g. a glitch), the next up step goes to 0 and the next down step goes to MOD-1.
- Asserting clr mid-count overrides everything, including a pending load or sclr.

Decomposition:
- Shared package (counter_pkg):
  - direction constants DIR_UP=1, DIR_DOWN=0;
  - a function giving the digit width for a modulus;
  - a function clamping a digit to MOD-1.
- Sub-module modn_digit, instantiated DIGITS times via generate.
  - Inputs: clk, clr, step, up, sclr, load, load_digit.
  - Outputs: q_digit, at_term.
- The top level holds:
  - the AND-chain of at_term signals that builds each digit's step;
  - carry_out;
  - the wrap register.

Test Plan (MOD=6, DIGITS=2, W=3; values written as digit1:digit0):
- Up count: clr pulse, then en=1, up=1 for 36 edges. Sequence runs 0:0, 0:1 ... 0:5, 1:0 ... 5:5, 0:0. carry_out is 1 only while at 5:5. wrap=1 for exactly the one cycle following the 5:5 -> 0:0 edge.
- Down count: from 0:0 with en=1, up=0, one edge gives 5:5; the next edge gives 5:4. carry_out=1 while at 0:0. wrap pulses once.
- Load with clamp: load=1, load_val digits 7:2 (bits 6'b111_010) gives q=5:2. A second load of 3:4 gives q=3:4.
- Priority: sclr=1, load=1 and en=1 on the same edge give q=0:0 and wrap=0. With load=1 and en=1 only, q=load_val and the count is not applied.
- Async reset mid-count: at q=3:4, drive clr low between edges. q=0:0 and wrap=0 immediately, without a clock edge. After clr returns high, counting resumes from 0:0.
- Direction flip and hold: at q=2:5, up=1 gives 3:0. Then at q=3:0, up=0 gives 2:5. With en=0 for 3 edges, q stays 2:5 and carry_out=0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the modulo counter family.
//   DIR_UP / DIR_DOWN : values of the 'up' direction input.
//   digit_width()     : bits needed to hold one digit of a given modulus.
//   clamp_digit()     : limits a digit value to mod-1 (digits are at most 8 bits).
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // A modulus of 2 still needs one bit; $clog2(2) already gives 1, the guard
  // covers any caller passing a degenerate modulus.
  function automatic int unsigned digit_width(input int unsigned mod);
    if (mod <= 2) return 1;
    return $clog2(mod);
  endfunction

  function automatic logic [7:0] clamp_digit(input logic [7:0] d,
                                             input int unsigned mod);
    if (32'(d) >= mod) return 8'(mod - 1);
    return d;
  endfunction

endpackage

// File: rtl/modn_digit.sv
// One modulo-MOD digit of the cascade counter.
// Ports:
//   clk        rising-edge clock
//   clr        asynchronous active-low reset, digit -> 0
//   step       advance this digit on the edge (lowest priority)
//   up         direction, 1 = up, 0 = down
//   sclr       synchronous clear (highest priority)
//   load       synchronous load of load_digit (clamped to MOD-1)
//   load_digit value to load
//   q_digit    current digit value
//   at_term    digit sits at its terminal value for the current direction
module modn_digit
  import counter_pkg::*;
#(
  parameter int MOD = 6,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         step,
  input  logic         up,
  input  logic         sclr,
  input  logic         load,
  input  logic [W-1:0] load_digit,
  output logic [W-1:0] q_digit,
  output logic         at_term
);

  localparam logic [W-1:0] MAX = W'(MOD - 1);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  logic [W-1:0] load_clamped;

  assign load_clamped = W'(clamp_digit(8'(load_digit), MOD));

  assign at_term = (up == DIR_UP) ? (q_q == MAX) : (q_q == '0);

  // Out-of-range values (only reachable by a glitch) fold back into range:
  // up goes to 0, down goes to MAX.
  always_comb begin
    q_d = q_q;
    if (sclr) begin
      q_d = '0;
    end else if (load) begin
      q_d = load_clamped;
    end else if (step) begin
      if (up == DIR_UP) begin
        if (q_q >= MAX) q_d = '0;
        else            q_d = q_q + W'(1);
      end else begin
        if ((q_q == '0) || (q_q > MAX)) q_d = MAX;
        else                            q_d = q_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q_digit = q_q;

endmodule

// File: rtl/modn_cascade_counter.sv
// Synchronous cascade of DIGITS modulo-MOD digits with up/down, enable,
// synchronous clear/load, a combinational cascade carry and a registered
// wrap pulse. All flops share clk; carries are enables, never clocks.
// Ports:
//   clk        rising-edge clock
//   clr        asynchronous active-low reset (q and wrap -> 0)
//   en         count enable
//   up         direction, 1 = up, 0 = down
//   sclr       synchronous clear, beats load and en
//   load       synchronous parallel load, beats en
//   load_val   load value, digit i in [i*W +: W]
//   q          count, digit 0 least significant
//   carry_out  en and every digit at its terminal value (0 during sclr/load)
//   wrap       one-cycle pulse after an edge where carry_out was 1
module modn_cascade_counter
  import counter_pkg::*;
#(
  parameter int MOD    = 6,
  parameter int DIGITS = 2
) (
  input  logic                                  clk,
  input  logic                                  clr,
  input  logic                                  en,
  input  logic                                  up,
  input  logic                                  sclr,
  input  logic                                  load,
  input  logic [DIGITS*digit_width(MOD)-1:0]    load_val,
  output logic [DIGITS*digit_width(MOD)-1:0]    q,
  output logic                                  carry_out,
  output logic                                  wrap
);

  localparam int W = digit_width(MOD);

  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] at_term;
  logic              wrap_q;
  logic              wrap_d;

  // step[i] = en & at_term[0] & ... & at_term[i-1]; the digits themselves
  // give sclr/load priority over step.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_first
      assign step[i] = en;
    end else begin : g_rest
      assign step[i] = step[i-1] & at_term[i-1];
    end

    modn_digit #(
      .MOD (MOD),
      .W   (W)
    ) u_digit (
      .clk        (clk),
      .clr        (clr),
      .step       (step[i]),
      .up         (up),
      .sclr       (sclr),
      .load       (load),
      .load_digit (load_val[i*W +: W]),
      .q_digit    (q[i*W +: W]),
      .at_term    (at_term[i])
    );
  end

  assign carry_out = step[DIGITS-1] & at_term[DIGITS-1] & ~sclr & ~load;

  // carry_out is already 0 under sclr/load, so wrap clears on those edges.
  assign wrap_d = carry_out;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) wrap_q <= 1'b0;
    else      wrap_q <= wrap_d;
  end

  assign wrap = wrap_q;

endmodule

// File: tb/tb_modn_cascade_counter.sv
module tb_modn_cascade_counter;

  localparam int MOD    = 6;
  localparam int DIGITS = 2;
  localparam int W      = 3;

  logic                clk;
  logic                clr;
  logic                en;
  logic                up;
  logic                sclr;
  logic                load;
  logic [DIGITS*W-1:0] load_val;
  logic [DIGITS*W-1:0] q;
  logic                carry_out;
  logic                wrap;

  int checks   = 0;
  int failures = 0;

  modn_cascade_counter #(
    .MOD    (MOD),
    .DIGITS (DIGITS)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .en        (en),
    .up        (up),
    .sclr      (sclr),
    .load      (load),
    .load_val  (load_val),
    .q         (q),
    .carry_out (carry_out),
    .wrap      (wrap)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // helpers
  function automatic logic [5:0] enc(input int d1, input int d0);
    logic [2:0] a;
    logic [2:0] b;
    a = 3'(d1);
    b = 3'(d0);
    return {a, b};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int d1, input int d0);
    en       = 1'b0;
    sclr     = 1'b0;
    load     = 1'b1;
    load_val = enc(d1, d0);
    tick();
    load     = 1'b0;
  endtask

  initial begin
    int cnt;
    clr      = 1'b0;
    en       = 1'b0;
    up       = 1'b1;
    sclr     = 1'b0;
    load     = 1'b0;
    load_val = '0;
    #3;
    check("reset_q", 32'(q), 32'(enc(0, 0)));
    check("reset_wrap", 32'(wrap), 32'd0);
    check("reset_carry_up", 32'(carry_out), 32'd0);
    tick();
    clr = 1'b1;
    tick();
    check("post_release_q", 32'(q), 32'(enc(0, 0)));

    // up count over the full 36-state chain
    en  = 1'b1;
    up  = 1'b1;
    cnt = 0;
    for (int k = 0; k < 36; k++) begin
      #1;
      check($sformatf("up_carry_%0d", k), 32'(carry_out), 32'(k == 35));
      tick();
      cnt = (cnt + 1) % 36;
      check($sformatf("up_q_%0d", k), 32'(q), 32'(enc(cnt / 6, cnt % 6)));
      check($sformatf("up_wrap_%0d", k), 32'(wrap), 32'(k == 35));
    end
    tick();
    check("up_after_wrap_q", 32'(q), 32'(enc(0, 1)));
    check("up_after_wrap_wrap", 32'(wrap), 32'd0);

    // down count from 0:0
    en   = 1'b0;
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    check("sclr_q", 32'(q), 32'(enc(0, 0)));
    en = 1'b1;
    up = 1'b0;
    #1;
    check("down_carry_at_00", 32'(carry_out), 32'd1);
    tick();
    check("down_q_55", 32'(q), 32'(enc(5, 5)));
    check("down_wrap", 32'(wrap), 32'd1);
    check("down_carry_at_55", 32'(carry_out), 32'd0);
    tick();
    check("down_q_54", 32'(q), 32'(enc(5, 4)));
    check("down_wrap_gone", 32'(wrap), 32'd0);

    // load with clamp
    do_load(7, 2);
    check("load_clamp_d1", 32'(q), 32'(enc(5, 2)));
    check("load_wrap", 32'(wrap), 32'd0);
    do_load(3, 4);
    check("load_34", 32'(q), 32'(enc(3, 4)));
    do_load(2, 6);
    check("load_clamp_d0", 32'(q), 32'(enc(2, 5)));

    // priority: sclr > load > en
    sclr     = 1'b1;
    load     = 1'b1;
    en       = 1'b1;
    up       = 1'b1;
    load_val = enc(3, 4);
    tick();
    check("prio_sclr_q", 32'(q), 32'(enc(0, 0)));
    check("prio_sclr_wrap", 32'(wrap), 32'd0);
    sclr     = 1'b0;
    up       = 1'b0;
    load_val = enc(1, 2);
    #1;
    check("prio_load_carry_suppressed", 32'(carry_out), 32'd0);
    tick();
    load = 1'b0;
    check("prio_load_q", 32'(q), 32'(enc(1, 2)));
    check("prio_load_wrap", 32'(wrap), 32'd0);

    // async reset mid-count, with wrap high and q non-zero
    do_load(3, 4);
    en = 1'b1;
    up = 1'b1;
    tick();
    check("pre_reset_q", 32'(q), 32'(enc(3, 5)));
    sclr = 1'b1;
    en   = 1'b0;
    tick();
    sclr = 1'b0;
    en   = 1'b1;
    up   = 1'b0;
    tick();
    check("pre_reset_q_55", 32'(q), 32'(enc(5, 5)));
    check("pre_reset_wrap", 32'(wrap), 32'd1);
    #2;
    clr = 1'b0;
    #1;
    check("async_q", 32'(q), 32'(enc(0, 0)));
    check("async_wrap", 32'(wrap), 32'd0);
    check("async_carry_down", 32'(carry_out), 32'd1);
    up = 1'b1;
    #1;
    check("async_carry_up", 32'(carry_out), 32'd0);
    clr = 1'b1;
    #1;
    check("release_no_edge_q", 32'(q), 32'(enc(0, 0)));
    tick();
    check("resume_q", 32'(q), 32'(enc(0, 1)));
    check("resume_wrap", 32'(wrap), 32'd0);

    // direction flip and hold
    do_load(2, 5);
    en = 1'b1;
    up = 1'b1;
    tick();
    check("flip_up_q", 32'(q), 32'(enc(3, 0)));
    up = 1'b0;
    tick();
    check("flip_down_q", 32'(q), 32'(enc(2, 5)));
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("hold_q_%0d", k), 32'(q), 32'(enc(2, 5)));
      check($sformatf("hold_carry_%0d", k), 32'(carry_out), 32'd0);
    end

    // terminal state with en low gives no carry
    do_load(5, 5);
    up = 1'b1;
    #1;
    check("term_en0_carry", 32'(carry_out), 32'd0);
    en = 1'b1;
    #1;
    check("term_en1_carry", 32'(carry_out), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
